vector_checker: RTL and testbench

Synthesizable, parametrised self-checking engine for the single-cycle CPU bench flow. It holds a table of expected result vectors, compares the DUT result bus and NZCV-style flags against successive entries on each sample strobe, and counts mismatches. It records the first failing index and reports done/pass. It sits beside the CPU top and is loadable from a bench or a debug port, so a regression can run on silicon/FPGA without simulator-only checking.

---
 rtl/vector_checker.sv | 171 +++++++++++++++++
 tb/tb_vector_checker.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_checker.sv
// vector_checker: table-driven result checker for the single-cycle CPU flow.
// Holds DEPTH expected {last, flags, data} entries. Each sample strobe
// compares the DUT outputs against the next entry and counts mismatches.
// The block records the first failing index and reports done/pass.
// Optional build macro: CHECKER_STOP_ON_ERR_EN ends a run on its first failure.
module vector_checker #(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 100,
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_we,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic [FLAG_W+DATA_W:0]   load_data,
  input  logic                     start,
  input  logic                     cmp_flags,
  input  logic                     sample_en,
  input  logic [DATA_W-1:0]        dut_data,
  input  logic [FLAG_W-1:0]        dut_flags,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     mismatch,
  output logic [CNT_W-1:0]         err_count,
  output logic [CNT_W-1:0]         vec_count,
  output logic [ADDR_W-1:0]        first_err_idx,
  output logic                     first_err_vld
);

  localparam int ENT_W = 1 + FLAG_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                mode_flags_q, mode_flags_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [CNT_W-1:0]    vec_q, vec_d;
  logic [ADDR_W-1:0]   fidx_q, fidx_d;
  logic                fvld_q, fvld_d;
  logic                mism_q, mism_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  // Vector table; deliberately not reset so a loaded table survives a reset.
  logic [ENT_W-1:0]    mem_q [DEPTH];

  logic [ENT_W-1:0]    ent;
  logic                ent_last;
  logic [FLAG_W-1:0]   ent_flags;
  logic [DATA_W-1:0]   ent_data;
  logic                cmp_fail;
  logic                end_run;
  logic                load_ok;

  assign ent       = mem_q[ptr_q];
  assign ent_last  = ent[ENT_W-1];
  assign ent_flags = ent[DATA_W +: FLAG_W];
  assign ent_data  = ent[DATA_W-1:0];

  // Case-inequality so X/Z on DUT outputs shows up as a failure in simulation.
  assign cmp_fail = (dut_data !== ent_data) ||
                    (mode_flags_q && (dut_flags !== ent_flags));

  // Loads are only honoured outside a run and only for in-range indices.
  assign load_ok = load_we && (state_q != S_RUN) && (32'(load_addr) < DEPTH);

  // Table write port.
  always_ff @(posedge clk) begin
    if (load_ok) mem_q[load_addr] <= load_data;
  end

  // Next-state and output computation for the run controller.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    mode_flags_d = mode_flags_q;
    err_d        = err_q;
    vec_d        = vec_q;
    fidx_d       = fidx_q;
    fvld_d       = fvld_q;
    mism_d       = 1'b0;
    done_d       = done_q;
    pass_d       = pass_q;
    end_run      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RUN;
          ptr_d        = '0;
          mode_flags_d = cmp_flags;
          err_d        = '0;
          vec_d        = '0;
          fidx_d       = '0;
          fvld_d       = 1'b0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      S_RUN: begin
        if (sample_en) begin
          if (vec_q != '1) vec_d = vec_q + 1'b1;
          if (cmp_fail) begin
            mism_d = 1'b1;
            if (err_q != '1) err_d = err_q + 1'b1;
            if (!fvld_q) begin
              fidx_d = ptr_q;
              fvld_d = 1'b1;
            end
          end
          end_run = ent_last || (ptr_q == ADDR_W'(DEPTH - 1));
`ifdef CHECKER_STOP_ON_ERR_EN
          end_run = end_run || cmp_fail;
`endif
          if (end_run) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state; reset aborts any run immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      mode_flags_q <= 1'b0;
      err_q        <= '0;
      vec_q        <= '0;
      fidx_q       <= '0;
      fvld_q       <= 1'b0;
      mism_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      mode_flags_q <= mode_flags_d;
      err_q        <= err_d;
      vec_q        <= vec_d;
      fidx_q       <= fidx_d;
      fvld_q       <= fvld_d;
      mism_q       <= mism_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign busy          = (state_q == S_RUN);
  assign done          = done_q;
  assign pass          = pass_q;
  assign mismatch      = mism_q;
  assign err_count     = err_q;
  assign vec_count     = vec_q;
  assign first_err_idx = fidx_q;
  assign first_err_vld = fvld_q;

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench for vector_checker: expected mismatch bits are queued as
// samples are driven and popped when the registered mismatch appears.
module tb_vector_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_we;
  logic [6:0]  load_addr;
  logic [36:0] load_data;
  logic        start;
  logic        cmp_flags;
  logic        sample_en;
  logic [31:0] dut_data;
  logic [3:0]  dut_flags;
  logic        busy, done, pass, mismatch, first_err_vld;
  logic [15:0] err_count, vec_count;
  logic [6:0]  first_err_idx;

  int checks = 0;
  int failures = 0;
  logic sb[$];

  vector_checker dut (
    .clk(clk), .reset(rst_n), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .cmp_flags(cmp_flags),
    .sample_en(sample_en), .dut_data(dut_data), .dut_flags(dut_flags),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_count(err_count), .vec_count(vec_count),
    .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [6:0] a, input logic last, input logic [3:0] f,
                      input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = {last, f, d};
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic load_table();
    load(7'd0, 1'b0, 4'h0, 32'h5);
    load(7'd1, 1'b0, 4'h4, 32'h0);
    load(7'd2, 1'b1, 4'h0, 32'hA);
  endtask

  task automatic do_start(input logic cf);
    start = 1'b1; cmp_flags = cf;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive one cycle; when push=1 a compare is expected and its outcome queued.
  task automatic drive(input logic en, input logic [31:0] d, input logic [3:0] f,
                       input logic push, input logic ef);
    logic exp;
    sample_en = en; dut_data = d; dut_flags = f;
    if (push) sb.push_back(ef);
    @(negedge clk);
    exp = 1'b0;
    if (push) exp = sb.pop_front();
    checks++;
    if (mismatch !== exp) begin
      failures++;
      $display("FAIL mismatch_pulse t=%0t got=%0b exp=%0b", $time, mismatch, exp);
    end
    sample_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, pass, mismatch, first_err_vld} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, pass, mismatch, first_err_vld});
    end
    checks++;
    if ({err_count, vec_count, first_err_idx} !== 39'd0) begin
      failures++; $display("FAIL reset_counts got=%0h/%0h/%0h exp=0", err_count, vec_count, first_err_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass();
    load_table();
    do_start(1'b1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL pass_busy got=%0b exp=1", busy); end
    drive(1'b1, 32'h5, 4'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h0, 4'h4, 1'b1, 1'b0);
    drive(1'b1, 32'hA, 4'h0, 1'b1, 1'b0);
    checks++;
    if ({done, pass, busy, first_err_vld} !== 4'b1100) begin
      failures++; $display("FAIL pass_status got=%b exp=1100", {done, pass, busy, first_err_vld});
    end
    checks++;
    if (vec_count !== 16'd3 || err_count !== 16'd0) begin
      failures++; $display("FAIL pass_counts got=%0d/%0d exp=3/0", vec_count, err_count);
    end
  endtask

  task automatic test_data_mismatch();
    do_start(1'b1);
    drive(1'b1, 32'h5, 4'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h1, 4'h4, 1'b1, 1'b1);
`ifdef CHECKER_STOP_ON_ERR_EN
    drive(1'b1, 32'hA, 4'h0, 1'b0, 1'b0);
    checks++;
    if (vec_count !== 16'd2) begin failures++; $display("FAIL dm_vec got=%0d exp=2", vec_count); end
`else
    drive(1'b1, 32'hA, 4'h0, 1'b1, 1'b0);
    checks++;
    if (vec_count !== 16'd3) begin failures++; $display("FAIL dm_vec got=%0d exp=3", vec_count); end
`endif
    checks++;
    if ({done, pass, first_err_vld} !== 3'b101 || err_count !== 16'd1 || first_err_idx !== 7'd1) begin
      failures++;
      $display("FAIL dm_status got=done%0b pass%0b vld%0b err%0d idx%0d exp=done1 pass0 vld1 err1 idx1",
               done, pass, first_err_vld, err_count, first_err_idx);
    end
  endtask

  task automatic test_flags();
    do_start(1'b0);
    drive(1'b1, 32'h5, 4'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h0, 4'h8, 1'b1, 1'b0);
    drive(1'b1, 32'hA, 4'h0, 1'b1, 1'b0);
    checks++;
    if ({done, pass} !== 2'b11 || err_count !== 16'd0) begin
      failures++; $display("FAIL flags_off got=done%0b pass%0b err%0d exp=1/1/0", done, pass, err_count);
    end
    do_start(1'b1);
    drive(1'b1, 32'h5, 4'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h0, 4'h8, 1'b1, 1'b1);
`ifdef CHECKER_STOP_ON_ERR_EN
    drive(1'b1, 32'hA, 4'h0, 1'b0, 1'b0);
`else
    drive(1'b1, 32'hA, 4'h0, 1'b1, 1'b0);
`endif
    checks++;
    if ({done, pass} !== 2'b10 || err_count !== 16'd1 || first_err_idx !== 7'd1) begin
      failures++; $display("FAIL flags_on got=done%0b pass%0b err%0d idx%0d exp=1/0/1/1", done, pass, err_count, first_err_idx);
    end
  endtask

  task automatic test_gaps();
    do_start(1'b1);
    drive(1'b1, 32'h5, 4'h0, 1'b1, 1'b0);
    drive(1'b0, 32'hDEAD, 4'hF, 1'b0, 1'b0);
    drive(1'b0, 32'hBEEF, 4'hF, 1'b0, 1'b0);
    checks++;
    if (vec_count !== 16'd1 || busy !== 1'b1) begin
      failures++; $display("FAIL gaps_hold got=vec%0d busy%0b exp=1/1", vec_count, busy);
    end
    drive(1'b1, 32'h0, 4'h4, 1'b1, 1'b0);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL gaps_early_done got=%0b exp=0", done); end
    drive(1'b1, 32'hA, 4'h0, 1'b1, 1'b0);
    checks++;
    if ({done, pass} !== 2'b11 || vec_count !== 16'd3) begin
      failures++; $display("FAIL gaps_end got=done%0b pass%0b vec%0d exp=1/1/3", done, pass, vec_count);
    end
  endtask

  task automatic test_reset_mid_run();
    do_start(1'b1);
    drive(1'b1, 32'h7, 4'h0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mismatch, first_err_vld} !== 4'b0 || vec_count !== 16'd0 || err_count !== 16'd0) begin
      failures++;
      $display("FAIL async_reset got=busy%0b done%0b mism%0b vld%0b vec%0d err%0d exp=all0",
               busy, done, mismatch, first_err_vld, vec_count, err_count);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    do_start(1'b1);
    drive(1'b1, 32'h5, 4'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h0, 4'h4, 1'b1, 1'b0);
    drive(1'b1, 32'hA, 4'h0, 1'b1, 1'b0);
    checks++;
    if ({done, pass} !== 2'b11 || vec_count !== 16'd3) begin
      failures++; $display("FAIL rerun got=done%0b pass%0b vec%0d exp=1/1/3", done, pass, vec_count);
    end
  endtask

  task automatic test_load_in_run();
    do_start(1'b1);
    load_we = 1'b1; load_addr = 7'd2; load_data = {1'b1, 4'h0, 32'h77};
    drive(1'b1, 32'h5, 4'h0, 1'b1, 1'b0);
    load_we = 1'b0;
    drive(1'b1, 32'h0, 4'h4, 1'b1, 1'b0);
    drive(1'b1, 32'hA, 4'h0, 1'b1, 1'b0);
    checks++;
    if ({done, pass} !== 2'b11 || err_count !== 16'd0) begin
      failures++; $display("FAIL load_in_run got=done%0b pass%0b err%0d exp=1/1/0", done, pass, err_count);
    end
  endtask

  task automatic test_stop_on_err();
    do_start(1'b1);
    drive(1'b1, 32'h6, 4'h0, 1'b1, 1'b1);
`ifdef CHECKER_STOP_ON_ERR_EN
    drive(1'b1, 32'h0, 4'h4, 1'b0, 1'b0);
    drive(1'b1, 32'hA, 4'h0, 1'b0, 1'b0);
    checks++;
    if ({done, pass} !== 2'b10 || err_count !== 16'd1 || vec_count !== 16'd1) begin
      failures++; $display("FAIL stop_on_err got=done%0b pass%0b err%0d vec%0d exp=1/0/1/1", done, pass, err_count, vec_count);
    end
`else
    drive(1'b1, 32'h0, 4'h4, 1'b1, 1'b0);
    drive(1'b1, 32'hB, 4'h0, 1'b1, 1'b1);
    checks++;
    if ({done, pass} !== 2'b10 || err_count !== 16'd2 || vec_count !== 16'd3 || first_err_idx !== 7'd0) begin
      failures++; $display("FAIL multi_err got=done%0b pass%0b err%0d vec%0d idx%0d exp=1/0/2/3/0",
                           done, pass, err_count, vec_count, first_err_idx);
    end
`endif
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < 100; i++) load(7'(i), 1'b0, 4'(i), 32'h1000 + i);
    load(7'd100, 1'b1, 4'h0, 32'h0);
    do_start(1'b1);
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'h1000 + i, 4'(i), 1'b1, 1'b0);
      if (i == 98) begin
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL depth_early_done got=%0b exp=0", done); end
      end
    end
    checks++;
    if ({done, pass, busy} !== 3'b110 || vec_count !== 16'd100) begin
      failures++; $display("FAIL depth_end got=done%0b pass%0b busy%0b vec%0d exp=1/1/0/100", done, pass, busy, vec_count);
    end
  endtask

  initial begin
    load_we = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; cmp_flags = 1'b0;
    sample_en = 1'b0; dut_data = '0; dut_flags = '0;
    @(negedge clk);
    test_reset();
    test_pass();
    test_data_mismatch();
    test_flags();
    test_gaps();
    test_reset_mid_run();
    test_load_in_run();
    test_stop_on_err();
    test_full_depth();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
